// File: rtl/regfile_hilo_pkg.sv
// Shared types and bus layout for the regfile_hilo block.
// The write-back bus layout below is the single source of truth for the
// WB -> register-file bus.
package regfile_hilo_pkg;

    // Write-back bus width and field positions.
    localparam int WB_TO_RF_WD    = 104;
    localparam int RF_LO_WE       = 103;
    localparam int RF_LO_WDATA_HI = 102;
    localparam int RF_LO_WDATA_LO = 71;
    localparam int RF_HI_WE       = 70;
    localparam int RF_HI_WDATA_HI = 69;
    localparam int RF_HI_WDATA_LO = 38;
    localparam int RF_WE          = 37;
    localparam int RF_WADDR_HI    = 36;
    localparam int RF_WADDR_LO    = 32;
    localparam int RF_WDATA_HI    = 31;
    localparam int RF_WDATA_LO    = 0;

    // Register-file controller states.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_t;

    // Decoded view of the write-back bus.
    typedef struct packed {
        logic        lo_we;
        logic [31:0] lo_wdata;
        logic        hi_we;
        logic [31:0] hi_wdata;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } wb_to_rf_t;

    // Split the flat bus into named fields using the declared bit positions.
    function automatic wb_to_rf_t unpack_wb(input logic [WB_TO_RF_WD-1:0] bus);
        wb_to_rf_t f;
        f.lo_we    = bus[RF_LO_WE];
        f.lo_wdata = bus[RF_LO_WDATA_HI:RF_LO_WDATA_LO];
        f.hi_we    = bus[RF_HI_WE];
        f.hi_wdata = bus[RF_HI_WDATA_HI:RF_HI_WDATA_LO];
        f.rf_we    = bus[RF_WE];
        f.rf_waddr = bus[RF_WADDR_HI:RF_WADDR_LO];
        f.rf_wdata = bus[RF_WDATA_HI:RF_WDATA_LO];
        return f;
    endfunction

endpackage

// File: rtl/regfile_hilo_if.sv
// Bus bundle between the pipeline (WB producer / ID consumer) and the
// register file. The master side is the pipeline, the slave side is the
// register file.
interface regfile_hilo_if;
    import regfile_hilo_pkg::*;

    logic [WB_TO_RF_WD-1:0] wb_to_rf_bus;
    logic [4:0]             raddr1;
    logic [31:0]            rdata1;
    logic [4:0]             raddr2;
    logic [31:0]            rdata2;
    logic [31:0]            hi_rdata;
    logic [31:0]            lo_rdata;
    logic                   init_busy;

    modport master (
        output wb_to_rf_bus,
        output raddr1,
        output raddr2,
        input  rdata1,
        input  rdata2,
        input  hi_rdata,
        input  lo_rdata,
        input  init_busy
    );

    modport slave (
        input  wb_to_rf_bus,
        input  raddr1,
        input  raddr2,
        output rdata1,
        output rdata2,
        output hi_rdata,
        output lo_rdata,
        output init_busy
    );

endinterface

// File: rtl/regfile_hilo_hilo_reg.sv
// hilo_reg: HI/LO register pair with synchronous active-high reset and
// independent write enables, so a MULT/DIV result can update both at once.
// Optional same-cycle write-through when RF_WB_BYPASS_EN is defined; the
// byp_en input suppresses it while the register file is still clearing.
module hilo_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
`ifdef RF_WB_BYPASS_EN
    input  logic          byp_en,
`endif
    input  logic          hi_we,
    input  logic [DW-1:0] hi_wdata,
    input  logic          lo_we,
    input  logic [DW-1:0] lo_wdata,
    output logic [DW-1:0] hi_rdata,
    output logic [DW-1:0] lo_rdata
);

    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;

    // HI/LO storage: cleared by reset, each half written by its own enable.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_wdata;
            if (lo_we) lo_q <= lo_wdata;
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Read path with write-through of the value being written this cycle.
    // NOTE: every output of a combinational block gets a default first so no
    // path through it can leave a value held, which would infer a latch.
    always_comb begin
        hi_rdata = hi_q;
        lo_rdata = lo_q;
        if (byp_en && hi_we) hi_rdata = hi_wdata;
        if (byp_en && lo_we) lo_rdata = lo_wdata;
    end
`else
    // Read path returns stored values only.
    always_comb begin
        hi_rdata = hi_q;
        lo_rdata = lo_q;
    end
`endif

endmodule

// File: rtl/regfile_hilo.sv
// regfile_hilo: MIPS32 architectural GPR file plus HI/LO pair.
// After reset a 32-cycle sweep writes zero into every GPR so the array
// itself needs no reset and can map onto LUTRAM/BRAM; init_busy is high
// for the whole sweep and stalls fetch/decode.
// Optional feature macro: RF_WB_BYPASS_EN (same-cycle WB write-through on
// the GPR and HI/LO read ports, inactive during the sweep).
module regfile_hilo
    import regfile_hilo_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    regfile_hilo_if.slave      rf
);

    localparam logic [4:0] LAST_REG = 5'(NREG - 1);

    wb_to_rf_t     wb;
    rf_state_t     state;
    logic [4:0]    clr_cnt;
    logic          init_busy_q;
    logic [DW-1:0] gpr [NREG];
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          run;
    logic          gpr_wr;

    assign wb     = unpack_wb(rf.wb_to_rf_bus);
    assign run    = (state == ST_RUN);
    assign gpr_wr = run && wb.rf_we && (wb.rf_waddr != 5'd0);

    // Sweep controller: INIT walks clr_cnt over every entry, then parks in RUN
    // with clr_cnt frozen at the last index; init_busy is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            clr_cnt     <= 5'd0;
            init_busy_q <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    if (clr_cnt == LAST_REG) begin
                        state       <= ST_RUN;
                        init_busy_q <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 5'd1;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state       <= ST_INIT;
                    clr_cnt     <= 5'd0;
                    init_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // GPR write port: the sweep owns the port in INIT, WB writes own it in RUN.
    // NOTE: the array is deliberately not reset; the sweep clears it instead so
    // synthesis can still infer distributed/block RAM.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            gpr[clr_cnt] <= '0;
        end else if (gpr_wr) begin
            gpr[wb.rf_waddr] <= wb.rf_wdata;
        end
    end

    // Asynchronous read ports; $0 and the sweep both read as zero.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (run) begin
            if (rf.raddr1 != 5'd0) rdata1 = gpr[rf.raddr1];
            if (rf.raddr2 != 5'd0) rdata2 = gpr[rf.raddr2];
`ifdef RF_WB_BYPASS_EN
            if (gpr_wr && (rf.raddr1 == wb.rf_waddr)) rdata1 = wb.rf_wdata;
            if (gpr_wr && (rf.raddr2 == wb.rf_waddr)) rdata2 = wb.rf_wdata;
`endif
        end
    end

    assign rf.rdata1    = rdata1;
    assign rf.rdata2    = rdata2;
    assign rf.init_busy = init_busy_q;

    hilo_reg #(
        .DW(DW)
    ) u_hilo (
        .clk      (clk),
        .rst      (rst),
`ifdef RF_WB_BYPASS_EN
        .byp_en   (run),
`endif
        .hi_we    (wb.hi_we),
        .hi_wdata (wb.hi_wdata),
        .lo_we    (wb.lo_we),
        .lo_wdata (wb.lo_wdata),
        .hi_rdata (rf.hi_rdata),
        .lo_rdata (rf.lo_rdata)
    );

endmodule
